// File: rtl/sprite_physics_stepper.sv
// Per-frame sprite physics: velocity, gravity and edge reflection for each sprite,
// swept one sprite per cycle and committed to the display outputs in a single cycle.
module sprite_physics_stepper #(
  parameter int              SPRITES = 1,
  parameter logic signed [7:0] GRAVITY = 8'sd1,
  parameter int              MAX_V   = 20,
  parameter int              COL_MAX = 1473,
  parameter int              ROW_MAX = 1073
) (
  input  logic                      clock_162,
  input  logic                      rst_n,
  input  logic                      frame_start,
  input  logic                      run,
  output logic [SPRITES-1:0][10:0]  sprite_row,
  output logic [SPRITES-1:0][11:0]  sprite_col,
  output logic                      busy,
  output logic                      overrun
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] UPDATE = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam logic [2:0]         LAST_IDX = 3'(SPRITES - 1);
  localparam logic signed [8:0]  V_HI     = 9'(MAX_V);
  localparam logic signed [8:0]  V_LO     = -V_HI;
  localparam logic signed [12:0] C_MAX    = 13'(COL_MAX);
  localparam logic signed [12:0] R_MAX    = 13'(ROW_MAX);
  localparam logic signed [12:0] C_TWICE  = 13'(2 * COL_MAX);
  localparam logic signed [12:0] R_TWICE  = 13'(2 * ROW_MAX);

  logic [1:0] state;
  logic [2:0] idx;

  logic [11:0]       col [SPRITES];
  logic [10:0]       row [SPRITES];
  logic signed [7:0] vx  [SPRITES];
  logic signed [7:0] vy  [SPRITES];

  logic [11:0]        cur_col;
  logic [10:0]        cur_row;
  logic signed [7:0]  cur_vx;
  logic signed [7:0]  cur_vy;
  logic signed [8:0]  vy_sum;
  logic signed [7:0]  vy_n;
  logic signed [12:0] ncol;
  logic signed [12:0] nrow;
  logic signed [12:0] col_lo;
  logic signed [12:0] col_hi;
  logic signed [12:0] row_lo;
  logic signed [12:0] row_hi;
  logic [11:0]        new_col;
  logic [10:0]        new_row;
  logic signed [7:0]  new_vx;
  logic signed [7:0]  new_vy;

  assign busy = (state != IDLE);

  // Select the sprite currently addressed by the sweep index.
  always_comb begin
    cur_col = '0;
    cur_row = '0;
    cur_vx  = '0;
    cur_vy  = '0;
    for (int i = 0; i < SPRITES; i++) begin
      if (idx == 3'(i)) begin
        cur_col = col[i];
        cur_row = row[i];
        cur_vx  = vx[i];
        cur_vy  = vy[i];
      end
    end
  end

  // Semi-implicit step: the gravity-updated vy moves the row in the same frame.
  always_comb begin
    vy_sum = $signed({cur_vy[7], cur_vy}) + $signed({GRAVITY[7], GRAVITY});
    vy_n   = vy_sum[7:0];
    if (vy_sum > V_HI)
      vy_n = V_HI[7:0];
    else if (vy_sum < V_LO)
      vy_n = V_LO[7:0];

    ncol   = $signed({1'b0, cur_col}) + $signed({{5{cur_vx[7]}}, cur_vx});
    nrow   = $signed({2'b00, cur_row}) + $signed({{5{vy_n[7]}}, vy_n});
    col_lo = -ncol;
    col_hi = C_TWICE - ncol;
    row_lo = -nrow;
    row_hi = R_TWICE - nrow;

    new_col = ncol[11:0];
    new_vx  = cur_vx;
    if (ncol < 13'sd0) begin
      new_col = col_lo[11:0];
      new_vx  = -cur_vx;
    end else if (ncol > C_MAX) begin
      new_col = col_hi[11:0];
      new_vx  = -cur_vx;
    end

    new_row = nrow[10:0];
    new_vy  = vy_n;
    if (nrow < 13'sd0) begin
      new_row = row_lo[10:0];
      new_vy  = -vy_n;
    end else if (nrow > R_MAX) begin
      new_row = row_hi[10:0];
      new_vy  = -vy_n;
    end
  end

  always_ff @(posedge clock_162 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < SPRITES; i++) begin
        col[i]        <= 12'(100 + 200 * i);
        row[i]        <= 11'(100 + 100 * i);
        vx[i]         <= 8'(3 + i);
        vy[i]         <= '0;
        sprite_col[i] <= 12'(100 + 200 * i);
        sprite_row[i] <= 11'(100 + 100 * i);
      end
    end else begin
      if (frame_start && state != IDLE)
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (frame_start && run) begin
            state <= UPDATE;
            idx   <= '0;
          end
        end
        UPDATE: begin
          for (int i = 0; i < SPRITES; i++) begin
            if (idx == 3'(i)) begin
              col[i] <= new_col;
              row[i] <= new_row;
              vx[i]  <= new_vx;
              vy[i]  <= new_vy;
            end
          end
          if (idx == LAST_IDX)
            state <= COMMIT;
          else
            idx <= idx + 3'd1;
        end
        COMMIT: begin
          // All sprites become visible together so the display never tears.
          for (int i = 0; i < SPRITES; i++) begin
            sprite_col[i] <= col[i];
            sprite_row[i] <= row[i];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_physics_stepper.sv
// Bench for sprite_physics_stepper: a 1-sprite and a 4-sprite instance share stimulus
// and are checked every cycle against a frame-level physics model.
module tb_sprite_physics_stepper;

  localparam int GRAV  = 1;
  localparam int VMAX  = 20;
  localparam int CMAX  = 1473;
  localparam int RMAX  = 1073;

  logic clock_162   = 1'b0;
  logic rst_n       = 1'b0;
  logic frame_start = 1'b0;
  logic run         = 1'b0;

  logic [0:0][10:0] row1;
  logic [0:0][11:0] col1;
  logic             busy1;
  logic             ovr1;
  logic [3:0][10:0] row4;
  logic [3:0][11:0] col4;
  logic             busy4;
  logic             ovr4;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  check_en = 1'b0;

  // Model state, instance 0 = 1 sprite, instance 1 = 4 sprites.
  int  m_n    [2] = '{1, 4};
  int  m_col  [2][7];
  int  m_row  [2][7];
  int  m_vx   [2][7];
  int  m_vy   [2][7];
  int  m_ccol [2][7];
  int  m_crow [2][7];
  int  m_rem  [2];
  bit  m_ovr  [2];

  always #3 clock_162 = ~clock_162;

  sprite_physics_stepper #(.SPRITES(1)) u_dut1 (
    .clock_162   (clock_162),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .run         (run),
    .sprite_row  (row1),
    .sprite_col  (col1),
    .busy        (busy1),
    .overrun     (ovr1)
  );

  sprite_physics_stepper #(.SPRITES(4)) u_dut4 (
    .clock_162   (clock_162),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .run         (run),
    .sprite_row  (row4),
    .sprite_col  (col4),
    .busy        (busy4),
    .overrun     (ovr4)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_rem[k] = 0;
      m_ovr[k] = 1'b0;
      for (int i = 0; i < 7; i++) begin
        m_col[k][i]  = 100 + 200 * i;
        m_row[k][i]  = 100 + 100 * i;
        m_vx[k][i]   = 3 + i;
        m_vy[k][i]   = 0;
        m_ccol[k][i] = m_col[k][i];
        m_crow[k][i] = m_row[k][i];
      end
    end
  endfunction

  // One whole frame of physics for every sprite of instance k.
  function automatic void model_frame(input int k);
    int v, nc, nr;
    for (int i = 0; i < m_n[k]; i++) begin
      v = m_vy[k][i] + GRAV;
      if (v > VMAX) v = VMAX;
      if (v < -VMAX) v = -VMAX;
      nc = m_col[k][i] + m_vx[k][i];
      if (nc < 0) begin
        m_col[k][i] = -nc;
        m_vx[k][i]  = -m_vx[k][i];
      end else if (nc > CMAX) begin
        m_col[k][i] = 2 * CMAX - nc;
        m_vx[k][i]  = -m_vx[k][i];
      end else begin
        m_col[k][i] = nc;
      end
      nr = m_row[k][i] + v;
      if (nr < 0) begin
        m_row[k][i] = -nr;
        m_vy[k][i]  = -v;
      end else if (nr > RMAX) begin
        m_row[k][i] = 2 * RMAX - nr;
        m_vy[k][i]  = -v;
      end else begin
        m_row[k][i] = nr;
        m_vy[k][i]  = v;
      end
    end
  endfunction

  // A sweep occupies SPRITES+1 cycles, after which the new frame becomes visible.
  function automatic void model_edge(input int k);
    if (m_rem[k] > 0) begin
      if (frame_start) m_ovr[k] = 1'b1;
      m_rem[k]--;
      if (m_rem[k] == 0) begin
        for (int i = 0; i < 7; i++) begin
          m_ccol[k][i] = m_col[k][i];
          m_crow[k][i] = m_row[k][i];
        end
      end
    end else if (frame_start && run) begin
      model_frame(k);
      m_rem[k] = m_n[k] + 1;
    end
  endfunction

  always @(posedge clock_162 or negedge rst_n) begin
    if (!rst_n)
      model_reset();
    else begin
      model_edge(0);
      model_edge(1);
    end
  end

  always @(negedge clock_162) begin
    if (check_en) begin
      checkOutput("busy1", int'(busy1), int'(m_rem[0] > 0));
      checkOutput("ovr1", int'(ovr1), int'(m_ovr[0]));
      checkOutput("row1[0]", int'(row1[0]), m_crow[0][0]);
      checkOutput("col1[0]", int'(col1[0]), m_ccol[0][0]);
      checkOutput("busy4", int'(busy4), int'(m_rem[1] > 0));
      checkOutput("ovr4", int'(ovr4), int'(m_ovr[1]));
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("row4[%0d]", i), int'(row4[2'(i)]), m_crow[1][i]);
        checkOutput($sformatf("col4[%0d]", i), int'(col4[2'(i)]), m_ccol[1][i]);
      end
    end
  end

  task automatic doReset();
    @(negedge clock_162);
    #1 rst_n = 1'b0;
    frame_start = 1'b0;
    repeat (2) @(negedge clock_162);
    #1 rst_n = 1'b1;
  endtask

  // One frame_start pulse, then enough idle cycles for both sweeps to finish.
  task automatic applyStimulus(input bit run_val);
    @(negedge clock_162);
    frame_start = 1'b1;
    run         = run_val;
    @(negedge clock_162);
    frame_start = 1'b0;
    repeat (6) @(negedge clock_162);
  endtask

  task automatic runFrames(input int n);
    repeat (n) applyStimulus(1'b1);
  endtask

  task automatic frameAndCount(input bit second_pulse, output int c1, output int c4);
    @(negedge clock_162);
    frame_start = 1'b1;
    run         = 1'b1;
    c1 = 0;
    c4 = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock_162);
      frame_start = second_pulse && (c == 1);
      if (busy1) c1++;
      if (busy4) c4++;
    end
  endtask

  initial begin
    int c1, c4;
    repeat (2) @(posedge clock_162);
    check_en = 1'b1;
    doReset();

    checkOutput("reset_row4[3]", int'(row4[3]), 400);
    checkOutput("reset_col4[3]", int'(col4[3]), 700);

    frameAndCount(1'b0, c1, c4);
    checkOutput("f1_busy1_cycles", c1, 2);
    checkOutput("f1_busy4_cycles", c4, 5);
    checkOutput("f1_row1", int'(row1[0]), 101);
    checkOutput("f1_col1", int'(col1[0]), 103);

    runFrames(19);
    checkOutput("f20_row1", int'(row1[0]), 310);
    checkOutput("f20_col1", int'(col1[0]), 160);
    checkOutput("f20_model_row", m_crow[0][0], 310);
    runFrames(1);
    checkOutput("f21_row1", int'(row1[0]), 330);
    checkOutput("f21_model_vy", m_vy[0][0], 20);
    runFrames(37);
    checkOutput("f58_row1", int'(row1[0]), 1070);
    runFrames(1);
    checkOutput("f59_row1", int'(row1[0]), 1056);
    checkOutput("f59_col1", int'(col1[0]), 277);
    checkOutput("f59_model_vy", m_vy[0][0], -20);
    runFrames(1);
    checkOutput("f60_row1", int'(row1[0]), 1037);
    runFrames(397);
    checkOutput("f457_col1", int'(col1[0]), 1471);
    runFrames(1);
    checkOutput("f458_col1", int'(col1[0]), 1472);
    checkOutput("f458_model_vx", m_vx[0][0], -3);
    runFrames(1);
    checkOutput("f459_col1", int'(col1[0]), 1469);

    doReset();
    frameAndCount(1'b1, c1, c4);
    checkOutput("ovr_busy4_cycles", c4, 5);
    checkOutput("ovr_busy1_cycles", c1, 2);
    checkOutput("ovr_flag4", int'(ovr4), 1);
    checkOutput("ovr_flag1", int'(ovr1), 1);
    checkOutput("ovr_row4[3]", int'(row4[3]), 401);
    checkOutput("ovr_col4[3]", int'(col4[3]), 706);
    checkOutput("ovr_row4[0]", int'(row4[0]), 101);

    repeat (3) applyStimulus(1'b0);
    checkOutput("frozen_row4[3]", int'(row4[3]), 401);
    checkOutput("frozen_col4[3]", int'(col4[3]), 706);
    checkOutput("sticky_ovr4", int'(ovr4), 1);

    @(negedge clock_162);
    frame_start = 1'b1;
    run         = 1'b1;
    @(negedge clock_162);
    frame_start = 1'b0;
    @(posedge clock_162);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy4", int'(busy4), 0);
    checkOutput("midrst_ovr4", int'(ovr4), 0);
    checkOutput("midrst_row4[3]", int'(row4[3]), 400);
    checkOutput("midrst_col4[3]", int'(col4[3]), 700);
    checkOutput("midrst_row1", int'(row1[0]), 100);
    @(negedge clock_162);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clock_162);
    checkOutput("postrst_row4[3]", int'(row4[3]), 400);
    checkOutput("postrst_col4[0]", int'(col4[0]), 100);
    checkOutput("postrst_busy4", int'(busy4), 0);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clock_162);
      frame_start = ($urandom_range(0, 5) == 0);
      run         = ($urandom_range(0, 3) != 0);
      if (!rst_n)
        #1 rst_n = 1'b1;
      else if ($urandom_range(0, 399) == 0)
        #1 rst_n = 1'b0;
    end
    @(negedge clock_162);
    frame_start = 1'b0;
    #1 rst_n = 1'b1;
    repeat (8) @(negedge clock_162);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
